mips_multicycle_controller: RTL and testbench
=============================================

# mips_multicycle_controller

Main control unit for the multicycle MIPS core. It sequences the shared datapath through fetch, decode, execute, memory and writeback states. It drives the select lines of the single shared ALU (3-bit ALU control codes) and the register-file and memory strobes. It stalls on a memory-ready handshake.

## Interface
Parameters:
- none

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous, active-low reset
- Op  input  6  instruction[31:26], sampled from the instruction register
- Funct  input  6  instruction[5:0]
- Zero  input  1  ALU zero flag, same cycle
- MemReady  input  1  memory completed the current access this cycle
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  instruction-register load
- RegDst  output  1  write register: 0 = rt, 1 = rd
- MemtoReg  output  1  writeback data: 0 = ALUOut, 1 = memory data
- RegWrite  output  1  register-file write
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUControl  output  3  ALU operation code (table below)
- PCSrc  output  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  output  1  PC load enable
- IllegalOp  output  1  one-cycle pulse in DECODE for an unrecognised opcode
- State  output  4  current state, for debug

## Operation
- Moore FSM with a 4-bit state register; reset state is FETCH.
- Output decode is combinational from the state. The only Mealy terms are the MemReady gating and the Zero gating.
- Signals not listed for a state are 0. ALUControl defaults to 010.

ALU control codes:
- 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT, 100 = SLL

States, outputs and transitions:
- FETCH (0)
  - Outputs: ALUSrcB = 01, ADD, PCSrc = 00.
  - IRWrite and PCEn equal MemReady.
  - Stay in FETCH while MemReady = 0; go to DECODE when MemReady = 1.
- DECODE (1)
  - Outputs: ALUSrcB = 11, ADD.
  - Next state by Op:
    - 100011 (LW) or 101011 (SW) → MEMADR
    - 000000 (R-type) → EXEC
    - 000100 (BEQ) → BRANCH
    - 001000 (ADDI) → ADDIEX
    - 000010 (J) → JUMP
    - any other opcode → FETCH, with IllegalOp = 1
- MEMADR (2)
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ADD.
  - Go to MEMRD for LW, MEMWR for SW.
- MEMRD (3)
  - Outputs: IorD = 1.
  - Hold until MemReady = 1, then go to MEMWB.
- MEMWB (4)
  - Outputs: MemtoReg = 1, RegWrite = 1.
  - Go to FETCH.
- MEMWR (5)
  - Outputs: IorD = 1; MemWrite = 1, held for every cycle of the wait.
  - Hold until MemReady = 1, then go to FETCH.
- EXEC (6)
  - Outputs: ALUSrcA = 1, ALUSrcB = 00.
  - ALUControl by Funct:
    - 100000 → 010 (ADD)
    - 100010 → 110 (SUB)
    - 100100 → 000 (AND)
    - 100101 → 001 (OR)
    - 101010 → 111 (SLT)
    - 000000 → 100 (SLL)
    - any other Funct → 010 (ADD)
  - Go to ALUWB.
- ALUWB (7)
  - Outputs: RegDst = 1, RegWrite = 1.
  - Go to FETCH.
- BRANCH (8)
  - Outputs: ALUSrcA = 1, SUB, PCSrc = 01, PCEn = Zero.
  - Go to FETCH.
- ADDIEX (9)
  - Outputs: ALUSrcA = 1, ALUSrcB = 10, ADD.
  - Go to ADDIWB.
- ADDIWB (10)
  - Outputs: RegWrite = 1.
  - Go to FETCH.
- JUMP (11)
  - Outputs: PCSrc = 10, PCEn = 1.
  - Go to FETCH.
- Unused encodings 12–15 go to FETCH on the next edge; all outputs are at their defaults in those states.

## Timing
- While ResetN = 0:
  - State = FETCH.
  - IRWrite, PCEn, MemWrite, RegWrite and IllegalOp are forced to 0, regardless of MemReady.
  - All other outputs take their FETCH values: ALUSrcB = 01, ALUControl = 010, everything else 0.
- Reset deassertion takes effect on the first rising Clk edge with ResetN = 1.
- A reset asserted mid-instruction aborts the instruction immediately and asynchronously. No partial strobe is issued after ResetN falls.
- Cycle counts with MemReady held at 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal opcode 2.
- Each cycle MemReady = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- MemReady is ignored in all other states.
- Op and Funct must be stable from DECODE until the instruction completes; the instruction register guarantees this.

## Configuration
- Macro `MULTICYCLE_BNE_EN`.
- Defined:
  - Op 000101 (BNE) in DECODE goes to BRANCH.
  - A 1-bit register, captured in DECODE, records that the instruction is BNE.
  - In BRANCH, PCEn = ~Zero for BNE and Zero for BEQ.
- Undefined:
  - Op 000101 is illegal: IllegalOp pulses and the FSM returns to FETCH.
  - The extra register is absent.

## Test plan
- Reset: hold ResetN low with MemReady = 1 → State = 0 and IRWrite = PCEn = 0. Release ResetN → IRWrite = PCEn = 1 on the first cycle.
- R-type SUB (Op 000000, Funct 100010), MemReady = 1 → State sequence 0, 1, 6, 7, 0. ALUControl = 110 in EXEC. RegWrite = 1 and RegDst = 1 only in ALUWB.
- LW with MemReady low for 2 cycles in MEMRD → sequence 0, 1, 2, 3, 3, 3, 4, 0. IorD = 1 throughout MEMRD. RegWrite = 1 with MemtoReg = 1 only in MEMWB.
- BEQ:
  - Zero = 1 → PCEn = 1 and PCSrc = 01 in BRANCH.
  - Zero = 0 → PCEn = 0.
  - With the macro defined, Op 000101 and Zero = 0 → PCEn = 1.
- Illegal opcode 111111 → IllegalOp = 1 for exactly one cycle in DECODE, then State = 0.
- Reset mid-SW: pull ResetN low during MEMWR with MemReady = 0 → MemWrite drops to 0 immediately and State = 0.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback over the shared datapath, and stalls on the
// memory-ready handshake.
// Optional feature macro: MULTICYCLE_BNE_EN adds BNE support through the
// BRANCH state.
module mips_multicycle_controller (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e state_q, state_d;

    // State register; reset aborts any instruction and returns to FETCH
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) state_q <= S_FETCH;
        else         state_q <= state_d;
    end

`ifdef MULTICYCLE_BNE_EN
    logic bne_q, bne_d;

    // Remember in DECODE whether the branch is BNE so BRANCH can invert Zero
    always_comb begin
        bne_d = bne_q;
        if (state_q == S_DECODE) bne_d = (Op == OP_BNE);
    end

    // BNE flag register
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) bne_q <= 1'b0;
        else         bne_q <= bne_d;
    end
`endif

    // Next-state and Moore outputs, with MemReady/Zero as the only Mealy terms
    always_comb begin
        state_d    = S_FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        IllegalOp  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
                    OP_BNE:       state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (Funct)
                    6'b100000: ALUControl = ALU_ADD;
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    6'b000000: ALUControl = ALU_SLL;
                    default:   ALUControl = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
`ifdef MULTICYCLE_BNE_EN
                PCEn       = bne_q ? ~Zero : Zero;
`else
                PCEn       = Zero;
`endif
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Strobes are killed the instant reset asserts, independent of MemReady
        if (!ResetN) begin
            IRWrite   = 1'b0;
            PCEn      = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    assign State = 4'(state_q);

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed testbench for mips_multicycle_controller.
module tb_mips_multicycle_controller;

    logic       Clk = 1'b0;
    logic       ResetN;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       PCEn;
    logic       IllegalOp;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    mips_multicycle_controller dut (
        .Clk(Clk), .ResetN(ResetN), .Op(Op), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
        .IllegalOp(IllegalOp), .State(State)
    );

    always #5 Clk = ~Clk;

    // Advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; MemReady = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        #2;
        cyc();
        cyc();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", State); end
        total++; if (IRWrite !== 1'b0 || PCEn !== 1'b0) begin bad++; $display("FAIL reset_strobes: got IRWrite=%b PCEn=%b want 0 0", IRWrite, PCEn); end
        total++; if (ALUSrcB !== 2'b01 || ALUControl !== 3'b010 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || IllegalOp !== 1'b0 || IorD !== 1'b0 || PCSrc !== 2'b00 || ALUSrcA !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got ALUSrcB=%b ALUControl=%b MemWrite=%b RegWrite=%b want 01 010 0 0", ALUSrcB, ALUControl, MemWrite, RegWrite);
        end
        ResetN = 1'b1;
        #1;
        total++; if (IRWrite !== 1'b1 || PCEn !== 1'b1 || State !== 4'd0) begin bad++; $display("FAIL reset_release: got IRWrite=%b PCEn=%b State=%0d want 1 1 0", IRWrite, PCEn, State); end
    endtask

    task automatic test_fetch_stall();
        MemReady = 1'b0;
        #1;
        total++; if (IRWrite !== 1'b0 || PCEn !== 1'b0) begin bad++; $display("FAIL fetch_stall_strobe: got IRWrite=%b PCEn=%b want 0 0", IRWrite, PCEn); end
        cyc();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL fetch_stall_state: got %0d want 0", State); end
        MemReady = 1'b1;
        #1;
    endtask

    task automatic test_rtype_sub();
        int exp_st[5] = '{0, 1, 6, 7, 0};
        Op = 6'b000000; Funct = 6'b100010; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            total++; if (State !== 4'(exp_st[i])) begin bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            if (exp_st[i] == 6) begin
                total++; if (ALUControl !== 3'b110 || ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00) begin bad++; $display("FAIL rtype_exec: got ALUControl=%b ALUSrcA=%b ALUSrcB=%b want 110 1 00", ALUControl, ALUSrcA, ALUSrcB); end
            end
            total++; if (RegWrite !== (exp_st[i] == 7) || RegDst !== (exp_st[i] == 7)) begin bad++; $display("FAIL rtype_wb[%0d]: got RegWrite=%b RegDst=%b", i, RegWrite, RegDst); end
        end
    endtask

    task automatic test_funct_table();
        logic [5:0] fn [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
        logic [2:0] ac [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b010};
        Op = 6'b000000; MemReady = 1'b1;
        for (int k = 0; k < 7; k++) begin
            Funct = fn[k];
            cyc(); cyc();
            total++; if (State !== 4'd6 || ALUControl !== ac[k]) begin bad++; $display("FAIL funct_%b: got State=%0d ALUControl=%b want 6 %b", fn[k], State, ALUControl, ac[k]); end
            cyc(); cyc();
        end
    endtask

    task automatic test_lw_stall();
        int exp_st[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
        Op = 6'b100011; MemReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            MemReady = (i == 3 || i == 4) ? 1'b0 : 1'b1;
            #1;
            total++; if (State !== 4'(exp_st[i])) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            if (exp_st[i] == 3) begin
                total++; if (IorD !== 1'b1) begin bad++; $display("FAIL lw_iord[%0d]: got %b want 1", i, IorD); end
            end
            if (exp_st[i] == 2) begin
                total++; if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b10 || ALUControl !== 3'b010) begin bad++; $display("FAIL lw_memadr: got ALUSrcA=%b ALUSrcB=%b ALUControl=%b", ALUSrcA, ALUSrcB, ALUControl); end
            end
            total++; if (RegWrite !== (exp_st[i] == 4) || MemtoReg !== (exp_st[i] == 4)) begin bad++; $display("FAIL lw_wb[%0d]: got RegWrite=%b MemtoReg=%b", i, RegWrite, MemtoReg); end
        end
        MemReady = 1'b1;
    endtask

    task automatic test_sw();
        int exp_st[5] = '{0, 1, 2, 5, 0};
        Op = 6'b101011; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            total++; if (State !== 4'(exp_st[i])) begin bad++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            total++; if (MemWrite !== (exp_st[i] == 5)) begin bad++; $display("FAIL sw_memwrite[%0d]: got %b", i, MemWrite); end
        end
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_en, input string nm);
        int exp_st[4] = '{0, 1, 8, 0};
        Op = op; Zero = z; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            total++; if (State !== 4'(exp_st[i])) begin bad++; $display("FAIL %s_state[%0d]: got %0d want %0d", nm, i, State, exp_st[i]); end
            if (exp_st[i] == 8) begin
                total++; if (PCEn !== exp_en || PCSrc !== 2'b01 || ALUControl !== 3'b110) begin bad++; $display("FAIL %s_branch: got PCEn=%b PCSrc=%b ALUControl=%b want %b 01 110", nm, PCEn, PCSrc, ALUControl, exp_en); end
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_illegal(input logic [5:0] op, input string nm);
        Op = op; MemReady = 1'b1;
        cyc();
        total++; if (State !== 4'd1 || IllegalOp !== 1'b1) begin bad++; $display("FAIL %s_decode: got State=%0d IllegalOp=%b want 1 1", nm, State, IllegalOp); end
        cyc();
        total++; if (State !== 4'd0 || IllegalOp !== 1'b0) begin bad++; $display("FAIL %s_return: got State=%0d IllegalOp=%b want 0 0", nm, State, IllegalOp); end
    endtask

    task automatic test_jump();
        Op = 6'b000010; MemReady = 1'b1;
        cyc(); cyc();
        total++; if (State !== 4'd11 || PCSrc !== 2'b10 || PCEn !== 1'b1) begin bad++; $display("FAIL jump: got State=%0d PCSrc=%b PCEn=%b want 11 10 1", State, PCSrc, PCEn); end
        cyc();
        total++; if (State !== 4'd0) begin bad++; $display("FAIL jump_return: got %0d want 0", State); end
    endtask

    task automatic test_addi();
        int exp_st[5] = '{0, 1, 9, 10, 0};
        Op = 6'b001000; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) cyc();
            total++; if (State !== 4'(exp_st[i])) begin bad++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, State, exp_st[i]); end
            total++; if (RegWrite !== (exp_st[i] == 10) || RegDst !== 1'b0) begin bad++; $display("FAIL addi_wb[%0d]: got RegWrite=%b RegDst=%b", i, RegWrite, RegDst); end
        end
    endtask

    task automatic test_reset_mid_sw();
        Op = 6'b101011; MemReady = 1'b1;
        cyc(); cyc(); cyc();
        MemReady = 1'b0;
        #1;
        total++; if (State !== 4'd5 || MemWrite !== 1'b1) begin bad++; $display("FAIL midsw_wait: got State=%0d MemWrite=%b want 5 1", State, MemWrite); end
        cyc();
        total++; if (State !== 4'd5 || MemWrite !== 1'b1) begin bad++; $display("FAIL midsw_hold: got State=%0d MemWrite=%b want 5 1", State, MemWrite); end
        #2;
        ResetN = 1'b0;
        #1;
        total++; if (MemWrite !== 1'b0 || State !== 4'd0) begin bad++; $display("FAIL midsw_abort: got MemWrite=%b State=%0d want 0 0", MemWrite, State); end
        cyc();
        ResetN = 1'b1; MemReady = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_rtype_sub();
        test_funct_table();
        test_lw_stall();
        test_sw();
        test_branch(6'b000100, 1'b1, 1'b1, "beq_taken");
        test_branch(6'b000100, 1'b0, 1'b0, "beq_not");
`ifdef MULTICYCLE_BNE_EN
        test_branch(6'b000101, 1'b0, 1'b1, "bne_taken");
        test_branch(6'b000101, 1'b1, 1'b0, "bne_not");
`else
        test_illegal(6'b000101, "bne_illegal");
`endif
        test_illegal(6'b111111, "illegal");
        test_jump();
        test_addi();
        test_reset_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
